// File: rtl/stopwatch_lap_core.sv
// stopwatch_lap_core
//   BCD stopwatch / countdown timer with a prescaled time base and a
//   first-word-fall-through lap FIFO.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   tick_en      in   time-base enable pulse
//   start_pause  in   toggles run / pause
//   clear        in   zeroes count and prescaler, returns to IDLE
//   lap          in   captures time_bcd into the lap FIFO (RUN/PAUSE only)
//   lap_rd       in   pops the lap FIFO head
//   mode_down    in   0 = count up, 1 = count down
//   load         in   presets the count from load_value (not in RUN)
//   load_value   in   BCD preset value
//   time_bcd     out  current count (registered)
//   running      out  FSM is in RUN
//   expired      out  FSM is in EXPIRED
//   lap_bcd      out  FIFO head (zero while FIFO empty)
//   lap_valid    out  FIFO not empty
//   lap_full     out  FIFO holds LAP_DEPTH entries
//   lap_overflow out  sticky: a lap capture was dropped
module stopwatch_lap_core #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 10,
  parameter int LAP_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick_en,
  input  logic                    start_pause,
  input  logic                    clear,
  input  logic                    lap,
  input  logic                    lap_rd,
  input  logic                    mode_down,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] time_bcd,
  output logic                    running,
  output logic                    expired,
  output logic [4*NUM_DIGITS-1:0] lap_bcd,
  output logic                    lap_valid,
  output logic                    lap_full,
  output logic                    lap_overflow
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int PW = 10;
  localparam int AW = $clog2(LAP_DEPTH);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [AW:0]   OCC_FULL   = (AW+1)'(LAP_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  // BCD increment; a digit above 9 that receives the carry is stepped as if it were 9.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    logic [3:0]   d;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = v[4*i +: 4];
      if (carry) begin
        if (d >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
          carry       = 1'b1;
        end else begin
          r[4*i +: 4] = d + 4'd1;
          carry       = 1'b0;
        end
      end else begin
        r[4*i +: 4] = d;
      end
    end
    return r;
  endfunction

  // BCD decrement; a digit above 9 that receives the borrow is stepped as if it were 9.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    logic [3:0]   d;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = v[4*i +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          r[4*i +: 4] = 4'd9;
          borrow      = 1'b1;
        end else if (d > 4'd9) begin
          r[4*i +: 4] = 4'd8;
          borrow      = 1'b0;
        end else begin
          r[4*i +: 4] = d - 4'd1;
          borrow      = 1'b0;
        end
      end else begin
        r[4*i +: 4] = d;
      end
    end
    return r;
  endfunction

  state_t        state_r, state_next;
  logic [W-1:0]  count_next;
  logic [W-1:0]  stepped_s;
  logic [PW-1:0] presc_r, presc_next;
  logic          step_s;

  logic [W-1:0]  mem_r [LAP_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   occ_r;
  logic          push_req_s, push_s, pop_s, full_s;

  // Next-state, next-count and prescaler logic with clear > load > start_pause priority.
  always_comb begin
    state_next = state_r;
    count_next = time_bcd;
    presc_next = presc_r;
    step_s     = 1'b0;
    stepped_s  = time_bcd;

    if ((state_r == RUN) && tick_en) begin
      if (presc_r == PRESC_LAST) begin
        presc_next = '0;
        step_s     = 1'b1;
      end else begin
        presc_next = presc_r + PW'(1);
      end
    end else begin
      presc_next = presc_r;
    end

    if (step_s) begin
      if (mode_down) begin
        stepped_s = bcd_dec(time_bcd);
        // Reaching zero while counting down ends the run on this same edge.
        if (stepped_s == '0) begin
          state_next = EXPIRED;
        end else begin
          state_next = state_r;
        end
      end else begin
        stepped_s = bcd_inc(time_bcd);
      end
      count_next = stepped_s;
    end else begin
      count_next = time_bcd;
    end

    if (clear) begin
      state_next = IDLE;
      count_next = '0;
      presc_next = '0;
    end else if (load) begin
      // A load during RUN is dropped and also masks start_pause.
      if (state_r != RUN) begin
        state_next = IDLE;
        count_next = load_value;
        presc_next = '0;
      end else begin
        state_next = state_next;
      end
    end else if (start_pause) begin
      case (state_r)
        IDLE: begin
          if (!(mode_down && (time_bcd == '0))) begin
            state_next = RUN;
          end else begin
            state_next = IDLE;
          end
        end
        RUN: begin
          // An expiry on the same edge takes precedence over pausing.
          if (state_next == RUN) begin
            state_next = PAUSE;
          end else begin
            state_next = state_next;
          end
        end
        PAUSE:   state_next = RUN;
        EXPIRED: state_next = EXPIRED;
        default: state_next = IDLE;
      endcase
    end else begin
      state_next = state_next;
    end
  end

  // State, count, prescaler and status flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      time_bcd <= '0;
      presc_r  <= '0;
      running  <= 1'b0;
      expired  <= 1'b0;
    end else begin
      state_r  <= state_next;
      time_bcd <= count_next;
      presc_r  <= presc_next;
      running  <= (state_next == RUN);
      expired  <= (state_next == EXPIRED);
    end
  end

  // Lap FIFO control: pop only when non-empty; a push into a full FIFO needs a same-cycle pop.
  always_comb begin
    full_s     = (occ_r == OCC_FULL);
    push_req_s = lap && ((state_r == RUN) || (state_r == PAUSE));
    pop_s      = lap_rd && (occ_r != '0);
    push_s     = push_req_s && (!full_s || pop_s);
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      occ_r        <= '0;
      lap_overflow <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + (AW+1)'(1);
        2'b01:   occ_r <= occ_r - (AW+1)'(1);
        default: occ_r <= occ_r;
      endcase
      if (push_req_s && full_s && !pop_s) begin
        lap_overflow <= 1'b1;
      end else begin
        lap_overflow <= lap_overflow;
      end
    end
  end

  // FIFO storage; contents are only observable through the valid-gated head.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= time_bcd;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  assign lap_valid = (occ_r != '0);
  assign lap_full  = (occ_r == OCC_FULL);
  assign lap_bcd   = lap_valid ? mem_r[rd_ptr_r] : '0;

endmodule
